mbr_store_unit: RTL and testbench
=================================

# mbr_store_unit

Memory write-back unit for the BitCruncher datapath, the store-direction counterpart of the operand-fetch path. Fetch moves MBR contents into the buffer register. This block moves an accumulator value out through the memory buffer register to RAM using a ready/strobe handshake with bounded wait. It holds a one-deep pending slot so the control unit can issue a second store while the first is in flight, and it reports completion, timeout and overflow back to the controller.

## Interface
- DATA_W, 16, width of stored data word
- ADDR_W, 8, width of memory address
- TIMEOUT, 15, maximum cycles spent in WRITE waiting for mem_ready (legal range 1..255)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- st_req  in  1  store request strobe from control unit; sampled every rising edge
- acc_in  in  DATA_W  data to store, captured with st_req
- mar_in  in  ADDR_W  target address, captured with st_req
- ovf_clr  in  1  clears ovf sticky flag
- mem_ready  in  1  RAM write acknowledge, sampled in WRITE
- mem_addr  out  ADDR_W  RAM address (MAR image)
- mem_wdata  out  DATA_W  RAM write data (MBR image)
- mem_we  out  1  RAM write strobe
- busy  out  1  high in every state except IDLE
- st_done  out  1  one-cycle completion pulse
- st_err  out  1  one-cycle pulse coincident with st_done when the write timed out
- ovf  out  1  sticky: a request was dropped because the pending slot was full

## Operation
- States: IDLE, SETUP, WRITE, DONE. Registered Moore outputs only; no combinational path from input to output.
- IDLE: mem_we=0. When st_req=1, capture {mar_in, acc_in} into mem_addr/mem_wdata and go to SETUP.
- SETUP: address and data are stable with mem_we=0 for exactly one cycle. Next state is WRITE. The wait counter clears to 0.
- WRITE: mem_we=1.
  - mem_ready=1 at an edge: go to DONE with err=0.
  - Otherwise the counter increments. If mem_ready=0 at the edge where the counter equals TIMEOUT-1, go to DONE with err=1.
  - mem_ready=1 on the timeout edge counts as success.
- DONE: mem_we=0 and st_done=1. st_err equals the latched err. Exit order:
  - If the pending slot is valid, load pending into mem_addr/mem_wdata, clear the slot, and go to SETUP.
  - Else if st_req=1, capture the inputs directly and go to SETUP.
  - Else go to IDLE.
- Pending slot (one entry, {addr, data, valid}):
  - In SETUP or WRITE, st_req=1 with the slot empty captures the inputs into the slot.
  - In SETUP or WRITE, st_req=1 with the slot full drops the request and sets ovf.
  - In DONE, when the slot drains and st_req=1 on the same edge, the new request refills the slot (not dropped).
- mem_addr and mem_wdata change only on capture edges. They hold from SETUP through DONE.
- ovf: set has priority over ovf_clr on the same edge. Otherwise ovf_clr clears it.

## Timing
- Reset values: state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, st_done=0, st_err=0, ovf=0, pending valid=0, counter=0.
- Reset mid-operation aborts immediately. mem_we drops asynchronously and the pending entry is discarded.
- Edge-by-edge sequence, for st_req sampled at edge E in IDLE:
  - After E: SETUP, busy=1.
  - After E+1: WRITE, mem_we=1.
  - mem_ready=1 at E+2 → after E+2: DONE, st_done=1.
  - After E+3: IDLE, or SETUP if there is more work.
- Minimum store: 3 busy cycles. Back-to-back via pending: 3-cycle issue interval.
- Worst case: WRITE lasts TIMEOUT cycles, so total busy cycles = TIMEOUT+2.
- st_done and st_err are high for exactly one cycle per accepted request. Dropped requests produce no st_done.

## Test plan
- Single store: st_req with mar_in=8'h3A, acc_in=16'hBEEF, mem_ready tied 1 → mem_we high one cycle with mem_addr=8'h3A, mem_wdata=16'hBEEF. st_done at E+2..E+3, st_err=0, busy for 3 cycles.
- Delayed ack: mem_ready asserted after 4 WRITE cycles → mem_we high 5 cycles, one st_done, st_err=0. Data/address stable throughout.
- Timeout: mem_ready held 0, TIMEOUT=15 → mem_we high exactly 15 cycles, then st_done=st_err=1 for one cycle, then IDLE. mem_ready=1 exactly on the 15th cycle → st_err=0.
- Pending and overflow: issue requests A (in IDLE), B (during SETUP), C (during WRITE).
  - A is written, then B, in that order.
  - C is dropped and ovf=1.
  - ovf_clr clears ovf; ovf_clr together with a new drop leaves ovf=1.
- DONE refill: with B pending, assert st_req D in A's DONE cycle → B goes to SETUP, D is held in the slot, ovf stays 0. Writes occur in order A, B, D.
- Reset mid-write: deassert rst_n during WRITE with a pending entry → mem_we=0 immediately and all outputs at reset values. After release, no further writes or st_done occur.

Source files
------------

// File: rtl/mbr_store_unit.sv
// ---------------------------------------------------------------------------
// mbr_store_unit
//
// Store-direction write-back unit for the BitCruncher datapath. It takes an
// accumulator value and a target address from the control unit and writes them
// to RAM through the MAR/MBR images. The write uses a mem_we / mem_ready
// handshake, and the wait for mem_ready is bounded. A one-entry pending slot
// lets the controller issue a second store while the first is still in flight.
//
// Parameters
//   DATA_W   width of the stored data word
//   ADDR_W   width of the memory address
//   TIMEOUT  maximum number of WRITE cycles spent waiting for mem_ready (1..255)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   st_req     store request strobe, sampled every rising edge
//   acc_in     data to store, captured with st_req
//   mar_in     target address, captured with st_req
//   ovf_clr    clears the ovf sticky flag
//   mem_ready  RAM write acknowledge, sampled while in WRITE
//   mem_addr   RAM address (MAR image)
//   mem_wdata  RAM write data (MBR image)
//   mem_we     RAM write strobe
//   busy       high in every state except IDLE
//   st_done    one-cycle completion pulse
//   st_err     one-cycle pulse alongside st_done when the write timed out
//   ovf        sticky flag: a request was dropped because the pending slot was full
// ---------------------------------------------------------------------------
module mbr_store_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_req,
    input  logic [DATA_W-1:0] acc_in,
    input  logic [ADDR_W-1:0] mar_in,
    input  logic              ovf_clr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              st_done,
    output logic              st_err,
    output logic              ovf
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    // Control decoded from the current state and the inputs.
    logic load_direct;  // capture mar_in/acc_in into the MAR/MBR images
    logic load_pend;    // move the pending entry into the MAR/MBR images
    logic pend_fill;    // capture mar_in/acc_in into the pending slot
    logic pend_clear;   // the pending slot drains and nothing refills it
    logic drop;         // request lost because the slot is full
    logic cnt_clr;
    logic cnt_inc;
    logic err_nx;       // the WRITE ends by timing out on this edge

    // NOTE: every signal driven here gets a default first, so that no path
    // through the case statement leaves a value unassigned. A missing default
    // is what makes the tool infer a latch.
    always_comb begin
        state_nx    = state;
        load_direct = 1'b0;
        load_pend   = 1'b0;
        pend_fill   = 1'b0;
        pend_clear  = 1'b0;
        drop        = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        err_nx      = 1'b0;

        unique case (state)
            IDLE: begin
                if (st_req) begin
                    load_direct = 1'b1;
                    state_nx    = SETUP;
                end
            end

            SETUP: begin
                cnt_clr  = 1'b1;
                state_nx = WRITE;
                if (st_req) begin
                    if (pend_valid) drop      = 1'b1;
                    else            pend_fill = 1'b1;
                end
            end

            WRITE: begin
                if (mem_ready) begin
                    // An acknowledge on the timeout edge still counts as success.
                    state_nx = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
                if (st_req) begin
                    if (pend_valid) drop      = 1'b1;
                    else            pend_fill = 1'b1;
                end
            end

            DONE: begin
                if (pend_valid) begin
                    // The slot drains on this edge, so a request arriving now
                    // refills it instead of being dropped.
                    load_pend = 1'b1;
                    state_nx  = SETUP;
                    if (st_req) pend_fill  = 1'b1;
                    else        pend_clear = 1'b1;
                end else if (st_req) begin
                    load_direct = 1'b1;
                    state_nx    = SETUP;
                end else begin
                    state_nx = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments. Every flop then
    // samples the values from before the edge, whatever the order in which
    // the blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state <= state_nx;

            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (load_direct) begin
                mem_addr  <= mar_in;
                mem_wdata <= acc_in;
            end else if (load_pend) begin
                mem_addr  <= pend_addr;
                mem_wdata <= pend_data;
            end

            if (pend_fill) begin
                pend_valid <= 1'b1;
                pend_addr  <= mar_in;
                pend_data  <= acc_in;
            end else if (pend_clear) begin
                pend_valid <= 1'b0;
            end

            // A drop takes priority over a clear on the same edge.
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;

            // The outputs are registered images of the next state. They are
            // glitch-free, and reset clears them asynchronously.
            mem_we  <= (state_nx == WRITE);
            busy    <= (state_nx != IDLE);
            st_done <= (state_nx == DONE);
            st_err  <= err_nx;
        end
    end

endmodule

// File: tb/tb_mbr_store_unit.sv
// ---------------------------------------------------------------------------
// tb_mbr_store_unit
//
// Directed testbench for mbr_store_unit. Inputs are driven and outputs are
// checked on the falling clock edge. A monitor runs 1 ns after each falling
// edge. It counts mem_we, st_done and st_err cycles, and it logs every write
// that the coming rising edge will complete (mem_we && mem_ready).
// ---------------------------------------------------------------------------
module tb_mbr_store_unit;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic              st_req;
    logic [DATA_W-1:0] acc_in;
    logic [ADDR_W-1:0] mar_in;
    logic              ovf_clr;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              busy;
    logic              st_done;
    logic              st_err;
    logic              ovf;

    mbr_store_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_req   (st_req),
        .acc_in   (acc_in),
        .mar_in   (mar_in),
        .ovf_clr  (ovf_clr),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .busy     (busy),
        .st_done  (st_done),
        .st_err   (st_err),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int we_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [ADDR_W+DATA_W-1:0] wr_log[$];

    always @(negedge clk) begin
        #1;
        if (mem_we)               we_cnt++;
        if (st_done)              done_cnt++;
        if (st_err)               err_cnt++;
        if (mem_we && mem_ready)  wr_log.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_mon();
        we_cnt   = 0;
        done_cnt = 0;
        err_cnt  = 0;
        wr_log.delete();
    endtask

    task automatic req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        st_req = 1'b1;
        mar_in = a;
        acc_in = d;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 40);
        check("reach_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [ADDR_W+DATA_W-1:0] got;
        got = (idx < wr_log.size()) ? wr_log[idx] : '1;
        check(tag, 32'(got), 32'({a, d}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        st_req    = 1'b0;
        acc_in    = '0;
        mar_in    = '0;
        ovf_clr   = 1'b0;
        mem_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_busy",  {31'd0, busy},    32'd0);
        check("rst_we",    {31'd0, mem_we},  32'd0);
        check("rst_done",  {31'd0, st_done}, 32'd0);
        check("rst_err",   {31'd0, st_err},  32'd0);
        check("rst_ovf",   {31'd0, ovf},     32'd0);
        check("rst_addr",  32'(mem_addr),    32'd0);
        check("rst_wdata", 32'(mem_wdata),   32'd0);
        rst_n = 1'b1;
        tick();

        // Single store, mem_ready tied high
        clear_mon();
        mem_ready = 1'b1;
        req(8'h3A, 16'hBEEF);
        tick();  // SETUP
        st_req = 1'b0;
        check("s1_setup_busy", {31'd0, busy},   32'd1);
        check("s1_setup_we",   {31'd0, mem_we}, 32'd0);
        check("s1_addr",       32'(mem_addr),   32'h3A);
        check("s1_wdata",      32'(mem_wdata),  32'hBEEF);
        tick();  // WRITE
        check("s1_write_we",   {31'd0, mem_we}, 32'd1);
        tick();  // DONE
        check("s1_done",       {31'd0, st_done}, 32'd1);
        check("s1_err",        {31'd0, st_err},  32'd0);
        check("s1_done_we",    {31'd0, mem_we},  32'd0);
        tick();  // IDLE
        check("s1_idle_busy",  {31'd0, busy},    32'd0);
        check("s1_idle_done",  {31'd0, st_done}, 32'd0);
        check("s1_we_cycles",  32'(we_cnt),      32'd1);
        check("s1_writes",     32'(wr_log.size()), 32'd1);
        check_write("s1_write0", 0, 8'h3A, 16'hBEEF);

        // Delayed ack: ready on the 5th WRITE cycle
        clear_mon();
        mem_ready = 1'b0;
        req(8'h5C, 16'h1234);
        tick();  // SETUP
        st_req = 1'b0;
        mar_in = 8'hFF;
        acc_in = 16'hFFFF;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("s2_we_c%0d", i),   {31'd0, mem_we}, 32'd1);
            check($sformatf("s2_addr_c%0d", i), 32'(mem_addr),   32'h5C);
            check($sformatf("s2_data_c%0d", i), 32'(mem_wdata),  32'h1234);
            if (i == 5) mem_ready = 1'b1;
        end
        tick();  // DONE
        check("s2_done", {31'd0, st_done}, 32'd1);
        check("s2_err",  {31'd0, st_err},  32'd0);
        check("s2_addr_done", 32'(mem_addr), 32'h5C);
        wait_idle();
        check("s2_we_cycles", 32'(we_cnt),   32'd5);
        check("s2_done_cnt",  32'(done_cnt), 32'd1);
        check("s2_writes",    32'(wr_log.size()), 32'd1);

        // Timeout with mem_ready held low
        clear_mon();
        mem_ready = 1'b0;
        req(8'h77, 16'hAAAA);
        tick();  // SETUP
        st_req = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) tick();
        check("s3_last_write_we", {31'd0, mem_we}, 32'd1);
        tick();  // DONE
        check("s3_done",    {31'd0, st_done}, 32'd1);
        check("s3_err",     {31'd0, st_err},  32'd1);
        check("s3_done_we", {31'd0, mem_we},  32'd0);
        tick();  // IDLE
        check("s3_idle_busy", {31'd0, busy},   32'd0);
        check("s3_idle_err",  {31'd0, st_err}, 32'd0);
        check("s3_we_cycles", 32'(we_cnt),     32'd15);
        check("s3_done_cnt",  32'(done_cnt),   32'd1);
        check("s3_err_cnt",   32'(err_cnt),    32'd1);
        check("s3_writes",    32'(wr_log.size()), 32'd0);

        // Ack exactly on the timeout edge counts as success
        clear_mon();
        req(8'h78, 16'hBBBB);
        tick();
        st_req = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i == TIMEOUT) mem_ready = 1'b1;
        end
        tick();  // DONE
        check("s3b_done", {31'd0, st_done}, 32'd1);
        check("s3b_err",  {31'd0, st_err},  32'd0);
        wait_idle();
        check("s3b_we_cycles", 32'(we_cnt),   32'd15);
        check("s3b_err_cnt",   32'(err_cnt),  32'd0);
        check("s3b_writes",    32'(wr_log.size()), 32'd1);

        // Pending slot and overflow: A in IDLE, B in SETUP, C in WRITE
        clear_mon();
        mem_ready = 1'b0;
        req(8'h11, 16'h1111);  // A
        tick();                // SETUP A
        req(8'h22, 16'h2222);  // B -> slot
        tick();                // WRITE A
        req(8'h33, 16'h3333);  // C -> dropped
        tick();
        st_req = 1'b0;
        check("s4_ovf_set", {31'd0, ovf},  32'd1);
        check("s4_addr_a",  32'(mem_addr), 32'h11);
        mem_ready = 1'b1;
        wait_idle();
        check("s4_done_cnt", 32'(done_cnt), 32'd2);
        check("s4_writes",   32'(wr_log.size()), 32'd2);
        check_write("s4_write0", 0, 8'h11, 16'h1111);
        check_write("s4_write1", 1, 8'h22, 16'h2222);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("s4_ovf_clr", {31'd0, ovf}, 32'd0);

        // ovf_clr on the same edge as a drop leaves ovf set
        clear_mon();
        mem_ready = 1'b0;
        req(8'h44, 16'h4444);
        tick();
        req(8'h55, 16'h5555);
        tick();
        req(8'h66, 16'h6666);
        ovf_clr = 1'b1;
        tick();
        st_req  = 1'b0;
        ovf_clr = 1'b0;
        check("s4_clr_vs_drop", {31'd0, ovf}, 32'd1);
        mem_ready = 1'b1;
        wait_idle();
        check("s4b_writes", 32'(wr_log.size()), 32'd2);
        check_write("s4b_write0", 0, 8'h44, 16'h4444);
        check_write("s4b_write1", 1, 8'h55, 16'h5555);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("s4b_ovf_clr", {31'd0, ovf}, 32'd0);

        // DONE refill: D arrives in A's DONE cycle while B drains from the slot
        clear_mon();
        mem_ready = 1'b0;
        req(8'hA1, 16'hA0A0);  // A
        tick();                // SETUP A
        req(8'hB2, 16'hB0B0);  // B -> slot
        tick();                // WRITE A
        st_req    = 1'b0;
        mem_ready = 1'b1;
        tick();                // DONE A
        check("s5_done_a", {31'd0, st_done}, 32'd1);
        req(8'hD4, 16'hD0D0);  // D refills the slot
        tick();                // SETUP B
        st_req = 1'b0;
        check("s5_setup_b_addr", 32'(mem_addr), 32'hB2);
        check("s5_setup_b_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        check("s5_ovf",      {31'd0, ovf},   32'd0);
        check("s5_done_cnt", 32'(done_cnt),  32'd3);
        check("s5_writes",   32'(wr_log.size()), 32'd3);
        check_write("s5_write0", 0, 8'hA1, 16'hA0A0);
        check_write("s5_write1", 1, 8'hB2, 16'hB0B0);
        check_write("s5_write2", 2, 8'hD4, 16'hD0D0);

        // Reset in the middle of a WRITE with a pending entry
        mem_ready = 1'b0;
        req(8'hC1, 16'hC1C1);
        tick();                // SETUP
        req(8'hC2, 16'hC2C2);  // -> slot
        tick();                // WRITE
        st_req = 1'b0;
        check("s6_we_before", {31'd0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_we_async",  {31'd0, mem_we},  32'd0);
        check("s6_busy",      {31'd0, busy},    32'd0);
        check("s6_addr",      32'(mem_addr),    32'd0);
        check("s6_wdata",     32'(mem_wdata),   32'd0);
        check("s6_done",      {31'd0, st_done}, 32'd0);
        check("s6_err",       {31'd0, st_err},  32'd0);
        check("s6_ovf",       {31'd0, ovf},     32'd0);
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        clear_mon();
        repeat (10) tick();
        check("s6_no_we",     32'(we_cnt),   32'd0);
        check("s6_no_done",   32'(done_cnt), 32'd0);
        check("s6_no_writes", 32'(wr_log.size()), 32'd0);
        check("s6_idle",      {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
